wb_cpu_bus_master: RTL
======================

// Module: wb_cpu_bus_master
// PURPOSE
// - Wishbone B4 classic master between CPU load/store unit and RAM/devices; parametrised in data width.
// - Steers byte lanes by address: SEL_O and DAT_O are shifted to the addressed lane; read data is shifted down and sign/zero extended.
// - Adds misalignment detection, an ERR_I response path, a one-cycle completion pulse and an optional bus timeout.
// PARAMETERS
// - DATA_W   32  bus data width, 32 or 64; SEL width is DATA_W/8; lane offset bits OFS_W = log2(DATA_W/8)
// - ADDR_W   32  address width
// - TMO_CYC  255 REQ cycles without ACK_I/ERR_I before abort (only with WB_BUS_TIMEOUT_EN); range 1..65535
// PORTS
// - CLK_I    in   1          clock, all state on rising edge
// - RST_N_I  in   1          asynchronous active-low reset
// - I_en     in   1          CPU request, level; accepted only in IDLE
// - I_op     in   3          `BUSOP_* code from busdefs.vh (READB/BU/H/HU/W, WRITEB/H/W)
// - I_addr   in   ADDR_W     byte address
// - I_data   in   32         store data, right-aligned
// - O_data   out  32         load result, extended; valid while O_done=1, then held
// - O_busy   out  1          state != IDLE
// - O_done   out  1          one-cycle completion pulse
// - O_err    out  1          qualifies O_done: misaligned, ERR_I or timeout
// - ACK_I    in   1          slave acknowledge
// - ERR_I    in   1          slave error
// - DAT_I    in   DATA_W     slave read data
// - ADR_O    out  ADDR_W     I_addr with low OFS_W bits zeroed
// - DAT_O    out  DATA_W     store data replicated into lanes
// - SEL_O    out  DATA_W/8   byte-lane selects
// - CYC_O, STB_O, WE_O  out  1 each
// BEHAVIOUR
// - Reset (async, RST_N_I=0): state IDLE; CYC_O/STB_O/WE_O/O_done/O_err=0; ADR_O/DAT_O/SEL_O/O_data=0; timeout counter 0.
//   Reset asserted mid-cycle drops CYC_O/STB_O immediately; no O_done for the aborted access.
// - States: IDLE -> REQ (I_en=1, aligned) | IDLE -> DONE (I_en=1, misaligned; no bus cycle);
//   REQ -> DONE on ACK_I, ERR_I or timeout; DONE -> IDLE unconditionally; DONE lasts exactly 1 cycle.
// - Accept edge registers ADR_O, SEL_O, DAT_O, WE_O and sets CYC_O=STB_O=1; they stay stable through REQ.
// - Lane rules: ofs = I_addr[OFS_W-1:0]; base mask B=1, H=2'b11, W=4'b1111; SEL_O = mask << ofs.
//   DAT_O = I_data byte/half/word replicated across DATA_W, so the selected lanes carry the data.
// - Misaligned: H with ofs[0]=1; W with ofs[1:0]!=0. Gives O_done=O_err=1 the cycle after accept; O_data is held.
// - Completion: REQ-cycle ACK_I/ERR_I sampled at edge; same edge clears CYC_O/STB_O/WE_O, enters DONE.
//   On ACK, O_data = (DAT_I >> 8*ofs) truncated to B/H/W, sign-extended for READB/READH, zero-extended for
//   READBU/READHU/READW. Writes leave O_data unchanged.
// - ERR_I and ACK_I in the same cycle: ERR_I wins, O_err=1, O_data unchanged.
// - ACK_I/ERR_I outside REQ are ignored.
// - Latency: accept edge N, CYC_O high in cycle N+1; zero-wait slave gives O_done in cycle N+2. Each wait state adds 1.
// - I_en during REQ/DONE is ignored. I_en still high in IDLE after DONE issues a new access (back-to-back, 1 idle cycle).
// - I_op/I_addr/I_data are sampled only at the accept edge.
// CONFIGURATION
// - WB_BUS_TIMEOUT_EN defined: counter clears on accept and increments each REQ cycle.
//   At count == TMO_CYC with no ACK_I/ERR_I: CYC_O/STB_O drop, DONE with O_err=1, O_data unchanged.
//   A late ACK_I is ignored.
// - Not defined: no counter logic; REQ waits indefinitely; TMO_CYC is unused.
// TESTING
// - DATA_W=32, READB addr 0x103, DAT_I=0x80AA5511, zero-wait ACK -> SEL_O=4'b1000, ADR_O=0x100,
//   O_data=0xFFFFFF80, O_done in cycle N+2, O_err=0.
// - DATA_W=64, WRITEH addr 0x206, I_data=0x1234 -> SEL_O=8'hC0, DAT_O=64'h1234123412341234, WE_O=1, ADR_O=0x200.
// - READW addr 0x102 -> no CYC_O; O_done=O_err=1 in cycle N+1; O_data held.
// - READHU addr 0x12, 3 wait states, then ACK_I with ERR_I, DAT_I=0xBEEF0000 -> O_err=1, O_done in cycle N+5, O_data unchanged.
// - WB_BUS_TIMEOUT_EN, TMO_CYC=4, slave silent -> CYC_O high for 4 cycles, then O_done=O_err=1;
//   ACK_I one cycle later is ignored.
// - RST_N_I pulsed low during REQ -> CYC_O/STB_O=0 asynchronously, O_busy=0, no O_done; the next request proceeds normally.

Source files
------------

// File: rtl/wb_cpu_bus_master.sv
// Wishbone B4 classic master for a CPU load/store unit.
// Moves store data onto the addressed byte lanes, returns load data shifted down
// and sign/zero extended, flags misaligned accesses and slave errors, and pulses
// O_done for one cycle when an access ends.
// Optional feature macro: WB_BUS_TIMEOUT_EN. When it is defined, an access is
// aborted with O_err after TMO_CYC REQ cycles that see no ACK_I and no ERR_I.
module wb_cpu_bus_master #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned TMO_CYC = 255
) (
  input  logic                CLK_I,
  input  logic                RST_N_I,
  input  logic                I_en,
  input  logic [2:0]          I_op,
  input  logic [ADDR_W-1:0]   I_addr,
  input  logic [31:0]         I_data,
  output logic [31:0]         O_data,
  output logic                O_busy,
  output logic                O_done,
  output logic                O_err,
  input  logic                ACK_I,
  input  logic                ERR_I,
  input  logic [DATA_W-1:0]   DAT_I,
  output logic [ADDR_W-1:0]   ADR_O,
  output logic [DATA_W-1:0]   DAT_O,
  output logic [DATA_W/8-1:0] SEL_O,
  output logic                CYC_O,
  output logic                STB_O,
  output logic                WE_O
);

  localparam int unsigned SEL_W = DATA_W / 8;
  localparam int unsigned OFS_W = $clog2(SEL_W);

  // Bus operation codes shared with the load/store unit.
  localparam logic [2:0] BUSOP_READB  = 3'd0;
  localparam logic [2:0] BUSOP_READBU = 3'd1;
  localparam logic [2:0] BUSOP_READH  = 3'd2;
  localparam logic [2:0] BUSOP_READHU = 3'd3;
  localparam logic [2:0] BUSOP_READW  = 3'd4;
  localparam logic [2:0] BUSOP_WRITEB = 3'd5;
  localparam logic [2:0] BUSOP_WRITEH = 3'd6;
  localparam logic [2:0] BUSOP_WRITEW = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_DONE
  } state_t;

  typedef enum logic [1:0] {
    SZ_B,
    SZ_H,
    SZ_W
  } size_t;

  state_t            state;
  state_t            state_nxt;

  // Request decode (valid at the accept edge only)
  size_t             req_size;
  logic              req_is_write;
  logic [OFS_W-1:0]  req_ofs;
  logic              req_mis;
  logic [SEL_W-1:0]  req_mask;
  logic [SEL_W-1:0]  req_sel;
  logic [DATA_W-1:0] req_dat;

  // Access context captured at accept, used when read data returns
  logic [2:0]        op_q;
  logic [OFS_W-1:0]  ofs_q;
  logic [31:0]       rd_lane;
  logic [31:0]       rd_ext;

  // FSM strobes
  logic              accept;
  logic              end_err;
  logic              end_ack;
  logic              tmo_hit;

  assign req_ofs = I_addr[OFS_W-1:0];

  // Decode operation size/direction, lane selects and replicated store data.
  always_comb begin
    req_size     = SZ_W;
    req_is_write = 1'b0;
    unique case (I_op)
      BUSOP_READB, BUSOP_READBU: req_size = SZ_B;
      BUSOP_READH, BUSOP_READHU: req_size = SZ_H;
      BUSOP_READW:               req_size = SZ_W;
      BUSOP_WRITEB: begin
        req_size     = SZ_B;
        req_is_write = 1'b1;
      end
      BUSOP_WRITEH: begin
        req_size     = SZ_H;
        req_is_write = 1'b1;
      end
      BUSOP_WRITEW: begin
        req_size     = SZ_W;
        req_is_write = 1'b1;
      end
      default: begin
        req_size     = SZ_W;
        req_is_write = 1'b0;
      end
    endcase

    req_mis  = 1'b0;
    req_mask = SEL_W'(4'b1111);
    req_dat  = {(DATA_W/32){I_data}};
    unique case (req_size)
      SZ_B: begin
        req_mask = SEL_W'(1'b1);
        req_dat  = {(DATA_W/8){I_data[7:0]}};
      end
      SZ_H: begin
        req_mis  = req_ofs[0];
        req_mask = SEL_W'(2'b11);
        req_dat  = {(DATA_W/16){I_data[15:0]}};
      end
      default: begin
        req_mis  = (req_ofs[1:0] != 2'b00);
        req_mask = SEL_W'(4'b1111);
        req_dat  = {(DATA_W/32){I_data}};
      end
    endcase
    req_sel = req_mask << req_ofs;
  end

  // Shift the addressed lane down to bit 0 and extend according to the load type.
  always_comb begin
    rd_lane = 32'(DAT_I >> {ofs_q, 3'b000});
    unique case (op_q)
      BUSOP_READB:  rd_ext = {{24{rd_lane[7]}}, rd_lane[7:0]};
      BUSOP_READBU: rd_ext = {24'h000000, rd_lane[7:0]};
      BUSOP_READH:  rd_ext = {{16{rd_lane[15]}}, rd_lane[15:0]};
      BUSOP_READHU: rd_ext = {16'h0000, rd_lane[15:0]};
      default:      rd_ext = rd_lane;
    endcase
  end

`ifdef WB_BUS_TIMEOUT_EN
  logic [15:0] tmo_cnt;

  // Count completed REQ cycles; the abort fires during the TMO_CYC-th one.
  always_ff @(posedge CLK_I or negedge RST_N_I) begin
    if (!RST_N_I) begin
      tmo_cnt <= '0;
    end else if (accept) begin
      tmo_cnt <= '0;
    end else if (state == S_REQ) begin
      tmo_cnt <= tmo_cnt + 16'd1;
    end
  end

  assign tmo_hit = (state == S_REQ) && (tmo_cnt == 16'(TMO_CYC - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  // State register.
  always_ff @(posedge CLK_I or negedge RST_N_I) begin
    if (!RST_N_I) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; ERR_I takes priority over ACK_I, both over the timeout.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    end_err   = 1'b0;
    end_ack   = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (I_en) begin
          accept    = 1'b1;
          end_err   = req_mis;
          state_nxt = req_mis ? S_DONE : S_REQ;
        end
      end
      S_REQ: begin
        if (ERR_I) begin
          end_err   = 1'b1;
          state_nxt = S_DONE;
        end else if (ACK_I) begin
          end_ack   = 1'b1;
          state_nxt = S_DONE;
        end else if (tmo_hit) begin
          end_err   = 1'b1;
          state_nxt = S_DONE;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Bus outputs, captured access context, load result and error flag.
  always_ff @(posedge CLK_I or negedge RST_N_I) begin
    if (!RST_N_I) begin
      ADR_O  <= '0;
      DAT_O  <= '0;
      SEL_O  <= '0;
      CYC_O  <= 1'b0;
      STB_O  <= 1'b0;
      WE_O   <= 1'b0;
      op_q   <= BUSOP_READB;
      ofs_q  <= '0;
      O_data <= '0;
      O_err  <= 1'b0;
    end else begin
      // end_err is only raised on the edge entering DONE, so O_err spans DONE exactly
      O_err <= end_err;
      if (accept && !req_mis) begin
        ADR_O <= {I_addr[ADDR_W-1:OFS_W], {OFS_W{1'b0}}};
        DAT_O <= req_dat;
        SEL_O <= req_sel;
        WE_O  <= req_is_write;
        CYC_O <= 1'b1;
        STB_O <= 1'b1;
        op_q  <= I_op;
        ofs_q <= req_ofs;
      end
      if (state == S_REQ && state_nxt == S_DONE) begin
        CYC_O <= 1'b0;
        STB_O <= 1'b0;
        WE_O  <= 1'b0;
      end
      if (end_ack && !WE_O) begin
        O_data <= rd_ext;
      end
    end
  end

  assign O_done = (state == S_DONE);
  assign O_busy = (state != S_IDLE);

endmodule
